// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache in front of a
// handshaked backing memory; stalls the pipeline while a transaction is open.
module dcache_responder #(
    parameter int LINES = 32,
    parameter int IDX_W = 5
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MemRead_fMEM,
    input  logic        MemWrite_fMEM,
    input  logic [31:0] data_address_fMEM,
    input  logic [31:0] data_write_fMEM,
    output logic [31:0] data_read_2MEM,
    output logic        FREEZE_2PIPE,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rd_req,
    output logic        mem_wr_req,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        WR_DONE = 2'd3
    } state_t;

    state_t            state_q;
    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q [LINES];
    logic [31:0]       data_q [LINES];
    logic              mem_rd_req_q;
    logic              mem_wr_req_q;
    logic [31:0]       mem_addr_q;
    logic [31:0]       mem_wdata_q;

    logic [31:0]       word_addr_s;
    logic [IDX_W-1:0]  idx_s;
    logic [TAG_W-1:0]  tag_s;
    logic [IDX_W-1:0]  lidx_s;
    logic [TAG_W-1:0]  ltag_s;
    logic              hit_s;
    logic              fill_s;
    logic              upd_s;
    logic              freeze_s;
    logic [31:0]       rdata_s;

    assign word_addr_s = data_address_fMEM & 32'hFFFF_FFFC;
    assign idx_s       = word_addr_s[IDX_W+1:2];
    assign tag_s       = word_addr_s[31:IDX_W+2];
    // The outstanding transaction is tracked purely through the latched address.
    assign lidx_s      = mem_addr_q[IDX_W+1:2];
    assign ltag_s      = mem_addr_q[31:IDX_W+2];
    assign hit_s       = valid_q[idx_s] && (tag_q[idx_s] == tag_s);
    assign fill_s      = (state_q == RD_WAIT) && mem_ack;
    assign upd_s       = (state_q == WR_WAIT) && mem_ack && valid_q[lidx_s] && (tag_q[lidx_s] == ltag_s);

    // Stall and load-data decode from the current state and request.
    always_comb begin
        freeze_s = 1'b0;
        rdata_s  = 32'd0;
        case (state_q)
            IDLE: begin
                if (MemWrite_fMEM) begin
                    freeze_s = 1'b1;
                end else if (MemRead_fMEM) begin
                    if (hit_s) begin
                        rdata_s = data_q[idx_s];
                    end else begin
                        freeze_s = 1'b1;
                    end
                end else begin
                    freeze_s = 1'b0;
                end
            end
            RD_WAIT, WR_WAIT: freeze_s = 1'b1;
            WR_DONE:          freeze_s = 1'b0;
            default:          freeze_s = 1'b0;
        endcase
    end

    // Control FSM with registered memory-side strobes, address and data.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= IDLE;
            valid_q      <= {LINES{1'b0}};
            mem_rd_req_q <= 1'b0;
            mem_wr_req_q <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (MemWrite_fMEM) begin
                        state_q      <= WR_WAIT;
                        mem_wr_req_q <= 1'b1;
                        mem_addr_q   <= word_addr_s;
                        mem_wdata_q  <= data_write_fMEM;
                    end else if (MemRead_fMEM && !hit_s) begin
                        state_q      <= RD_WAIT;
                        mem_rd_req_q <= 1'b1;
                        mem_addr_q   <= word_addr_s;
                    end
                end
                RD_WAIT: begin
                    if (mem_ack) begin
                        valid_q[lidx_s] <= 1'b1;
                        mem_rd_req_q    <= 1'b0;
                        state_q         <= IDLE;
                    end
                end
                WR_WAIT: begin
                    if (mem_ack) begin
                        mem_wr_req_q <= 1'b0;
                        state_q      <= WR_DONE;
                    end
                end
                WR_DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tag/data arrays; deliberately not reset, validity is carried by valid_q.
    always_ff @(posedge CLK) begin
        if (fill_s) begin
            tag_q[lidx_s]  <= ltag_s;
            data_q[lidx_s] <= mem_rdata;
        end else if (upd_s) begin
            data_q[lidx_s] <= mem_wdata_q;
        end
    end

    assign data_read_2MEM = rdata_s;
    assign FREEZE_2PIPE   = freeze_s;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign mem_rd_req     = mem_rd_req_q;
    assign mem_wr_req     = mem_wr_req_q;
endmodule

// File: doc/dcache_responder.md
DCACHE_RESPONDER -- requirements
Module: dcache_responder

Interface
REQ-001 Parameter LINES, default 32, number of direct-mapped one-word lines (power of two).
REQ-002 Parameter IDX_W, default 5, log2(LINES); index = addr[IDX_W+1:2], tag = addr[31:IDX_W+2].
REQ-003 CLK  input  1  clock; all state updates on posedge CLK.
REQ-004 RESET  input  1  reset, asynchronous, active-high.
REQ-005 MemRead_fMEM  input  1  load request from MEM stage, held until FREEZE_2PIPE low.
REQ-006 MemWrite_fMEM  input  1  store request from MEM stage, held until FREEZE_2PIPE low.
REQ-007 data_address_fMEM  input  32  byte address; bits [1:0] ignored (word granularity).
REQ-008 data_write_fMEM  input  32  store data.
REQ-009 data_read_2MEM  output  32  load data, combinational, valid when MemRead_fMEM high and FREEZE_2PIPE low.
REQ-010 FREEZE_2PIPE  output  1  pipeline stall.
REQ-011 mem_addr  output  32  backing-memory word address (bits [1:0] = 0).
REQ-012 mem_wdata  output  32  backing-memory write data.
REQ-013 mem_rd_req / mem_wr_req  output  1 each  backing-memory request strobes, held until ack.
REQ-014 mem_ack  input  1  backing-memory completion, one-cycle pulse.
REQ-015 mem_rdata  input  32  read data, valid in the cycle mem_ack is high.

Function
REQ-016 Storage: per line a valid bit, a tag and a 32-bit data word; write-through, no-write-allocate.
REQ-017 States: IDLE, RD_WAIT, WR_WAIT, WR_DONE.
REQ-018 hit = valid[idx] && tag[idx]==addr tag, evaluated combinationally on the current address.
REQ-019 IDLE, MemWrite_fMEM high (priority over MemRead_fMEM if both high): FREEZE_2PIPE high same cycle; next edge -> WR_WAIT, mem_wr_req=1, mem_addr/mem_wdata latched.
REQ-020 IDLE, MemRead_fMEM high, hit: data_read_2MEM = data[idx], FREEZE_2PIPE low, no state change.
REQ-021 IDLE, MemRead_fMEM high, miss: FREEZE_2PIPE high same cycle; next edge -> RD_WAIT, mem_rd_req=1, mem_addr latched.
REQ-022 RD_WAIT: FREEZE_2PIPE high; on edge with mem_ack: line[latched idx] <= {valid=1, latched tag, mem_rdata}, mem_rd_req=0, -> IDLE; the held load then hits the next cycle.
REQ-023 WR_WAIT: FREEZE_2PIPE high; on edge with mem_ack: mem_wr_req=0; if the latched address hits, update data word; -> WR_DONE.
REQ-024 WR_DONE: FREEZE_2PIPE low for exactly one cycle, incoming requests ignored; -> IDLE next edge.
REQ-025 Miss latency: load miss with mem_ack N cycles after mem_rd_req rises yields FREEZE_2PIPE high for N+2 cycles.
REQ-026 A request dropped while in RD_WAIT/WR_WAIT (flush/mispredict) does not cancel the outstanding transaction; it completes normally.
REQ-027 mem_ack in IDLE or WR_DONE is ignored; mem_rd_req and mem_wr_req are never high together.
REQ-028 data_read_2MEM = 0 when no load hit is presented.

Reset
REQ-029 RESET high: state IDLE, all valid bits 0, mem_rd_req=0, mem_wr_req=0, mem_addr=0, mem_wdata=0, FREEZE_2PIPE=0 (no request); tag/data arrays not cleared.
REQ-030 RESET asserted mid-transaction abandons it; a late mem_ack after reset release is ignored.

Verification
REQ-031 Cold load 0x00000040, mem_ack 3 cycles after mem_rd_req with mem_rdata=0xDEADBEEF -> FREEZE high 5 cycles, then data_read_2MEM=0xDEADBEEF; repeat load -> hit, no stall.
REQ-032 Store 0x00000040 data 0x12345678 after REQ-031 fill -> mem_wr_req with mem_addr=0x40, FREEZE low only in WR_DONE; subsequent load returns 0x12345678 with no stall.
REQ-033 Store to uncached 0x00000080 -> write-through issued, valid[0] unchanged; load 0x80 then misses.
REQ-034 Conflict: fill 0x40, then load 0x00000C0 (same index 16, different tag) -> miss, refill; load 0x40 misses again.
REQ-035 MemRead and MemWrite both high at 0x10 -> write path only, mem_rd_req stays 0.
REQ-036 RESET during RD_WAIT, then late mem_ack -> no line written, FREEZE 0, next load 0x40 misses.
